// File: rtl/alarm_time_set_pkg.sv
// Shared definitions for the alarm time-set block: button FSM encoding
// and the BCD digit limits used by the minute/hour steppers.
package alarm_time_set_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE   = 2'd0,
    BTN_WAIT   = 2'd1,
    BTN_REPEAT = 2'd2
  } btn_state_t;

  localparam logic [3:0] BCD_NINE  = 4'd9;
  localparam logic [3:0] BCD_FIVE  = 4'd5;
  localparam logic [3:0] BCD_TWO   = 4'd2;
  localparam logic [3:0] BCD_THREE = 4'd3;
  localparam logic [3:0] BCD_ONE   = 4'd1;

endpackage

// File: rtl/alarm_time_set_btn_repeat.sv
// Press/auto-repeat generator: one step on the press edge, then after
// REPEAT_DELAY cycles one step every REPEAT_PERIOD cycles while held.
// Releasing the button returns to IDLE at once with no further step.
module btn_repeat
  import alarm_time_set_pkg::*;
#(
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic step
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);

  btn_state_t    state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          btn_q;
  logic          step_next;

  // State, counter, previous-level and step registers. btn_q resets high so
  // a button already held when reset releases is not mistaken for a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BTN_IDLE;
      cnt   <= '0;
      btn_q <= 1'b1;
      step  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      btn_q <= btn;
      step  <= step_next;
    end
  end

  // Next-state, counter and step decision; release always wins.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    step_next  = 1'b0;
    if (!btn) begin
      state_next = BTN_IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        BTN_IDLE: begin
          if (!btn_q) begin
            step_next  = 1'b1;
            state_next = BTN_WAIT;
            cnt_next   = '0;
          end
        end
        BTN_WAIT: begin
          if (cnt == DELAY_LAST) begin
            step_next  = 1'b1;
            state_next = BTN_REPEAT;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
        BTN_REPEAT: begin
          if (cnt == PERIOD_LAST) begin
            step_next = 1'b1;
            cnt_next  = '0;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
        default: begin
          state_next = BTN_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/alarm_time_set.sv
// Alarm time setting and ringing: minute/hour buttons step BCD alarm
// digits (24 h or 12 h with PM flag), and the alarm rings once per rising
// match with the current time until stopped or RING_CYCLES elapse.
module alarm_time_set
  import alarm_time_set_pkg::*;
#(
  parameter bit              MODE24        = 1'b1,
  parameter int              REPEAT_DELAY  = 50_000_000,
  parameter int              REPEAT_PERIOD = 10_000_000,
  parameter longint unsigned RING_CYCLES   = 64'd3_000_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_min,
  input  logic       btn_hour,
  input  logic       btn_stop,
  input  logic       alarm_en,
  input  logic [3:0] cur_d0,
  input  logic [3:0] cur_d1,
  input  logic [3:0] cur_d2,
  input  logic [3:0] cur_d3,
  input  logic       cur_pm,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic       pm,
  output logic       ring
);

  localparam int RCW = $clog2(RING_CYCLES + 1);
  localparam logic [RCW-1:0] RING_LAST = RCW'(RING_CYCLES - 1);
  // 12 h mode starts at 12:00 AM, 24 h mode at 00:00.
  localparam logic [3:0] RST_D3 = MODE24 ? 4'd0 : BCD_ONE;
  localparam logic [3:0] RST_D2 = MODE24 ? 4'd0 : BCD_TWO;

  logic           min_step, hour_step;
  logic [3:0]     d0_next, d1_next, d2_next, d3_next;
  logic           pm_next;
  logic           match, match_q, stop_q, stop_edge, stop_cond;
  logic           ring_next;
  logic [RCW-1:0] ring_cnt, ring_cnt_next;

  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_min (
    .clk(clk), .rst_n(rst_n), .btn(btn_min), .step(min_step)
  );

  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_hour (
    .clk(clk), .rst_n(rst_n), .btn(btn_hour), .step(hour_step)
  );

  // Digit stepping; minute and hour fields are independent (no carry).
  always_comb begin
    d0_next = d0;
    d1_next = d1;
    d2_next = d2;
    d3_next = d3;
    pm_next = pm;
    if (min_step) begin
      if (d0 >= BCD_NINE) begin
        d0_next = 4'd0;
        d1_next = (d1 >= BCD_FIVE) ? 4'd0 : d1 + 4'd1;
      end else begin
        d0_next = d0 + 4'd1;
      end
    end
    if (hour_step) begin
      if (MODE24) begin
        if (d3 >= BCD_TWO && d2 >= BCD_THREE) begin
          d3_next = 4'd0;
          d2_next = 4'd0;
        end else if (d2 >= BCD_NINE) begin
          d2_next = 4'd0;
          d3_next = d3 + 4'd1;
        end else begin
          d2_next = d2 + 4'd1;
        end
      end else begin
        // 12 -> 01, 11 -> 12 flips AM/PM, otherwise plain BCD count.
        if (d3 == BCD_ONE && d2 >= BCD_TWO) begin
          d3_next = 4'd0;
          d2_next = BCD_ONE;
        end else if (d3 == BCD_ONE && d2 == BCD_ONE) begin
          d2_next = BCD_TWO;
          pm_next = ~pm;
        end else if (d2 >= BCD_NINE) begin
          d2_next = 4'd0;
          d3_next = BCD_ONE;
        end else begin
          d2_next = d2 + 4'd1;
        end
      end
    end
  end

  assign match     = alarm_en && (cur_d0 == d0) && (cur_d1 == d1) && (cur_d2 == d2) &&
                     (cur_d3 == d3) && (MODE24 || (cur_pm == pm));
  assign stop_edge = btn_stop && !stop_q;
  assign stop_cond = stop_edge || !alarm_en || min_step || hour_step ||
                     (ring && (ring_cnt == RING_LAST));

  // Ring control: any stop condition beats a new match edge; only a rising
  // match starts ringing, so a stopped alarm waits for match to drop first.
  always_comb begin
    ring_next     = ring;
    ring_cnt_next = ring_cnt;
    if (stop_cond) begin
      ring_next     = 1'b0;
      ring_cnt_next = '0;
    end else if (match && !match_q) begin
      ring_next     = 1'b1;
      ring_cnt_next = '0;
    end else if (ring) begin
      ring_cnt_next = ring_cnt + RCW'(1);
    end
  end

  // Alarm digits, ring state and edge-detect history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0       <= 4'd0;
      d1       <= 4'd0;
      d2       <= RST_D2;
      d3       <= RST_D3;
      pm       <= 1'b0;
      ring     <= 1'b0;
      ring_cnt <= '0;
      match_q  <= 1'b0;
      stop_q   <= 1'b1;
    end else begin
      d0       <= d0_next;
      d1       <= d1_next;
      d2       <= d2_next;
      d3       <= d3_next;
      pm       <= pm_next;
      ring     <= ring_next;
      ring_cnt <= ring_cnt_next;
      match_q  <= match;
      stop_q   <= btn_stop;
    end
  end

endmodule

// File: tb/tb_alarm_time_set.sv
// Bench for alarm_time_set: one 24 h and one 12 h instance share all inputs;
// each scenario task checks the instance relevant to it.
module tb_alarm_time_set;

  logic       clk, rst_n;
  logic       btn_min, btn_hour, btn_stop, alarm_en, cur_pm;
  logic [3:0] cur_d0, cur_d1, cur_d2, cur_d3;
  logic [3:0] a_d0, a_d1, a_d2, a_d3, b_d0, b_d1, b_d2, b_d3;
  logic       a_pm, a_ring, b_pm, b_ring;

  int n_cmp = 0;
  int n_fail = 0;
  logic [17:0] exp_q[$];
  logic [17:0] got, want;

  alarm_time_set #(.MODE24(1'b1), .REPEAT_DELAY(4), .REPEAT_PERIOD(2), .RING_CYCLES(64'd10)) dut24 (
    .clk(clk), .rst_n(rst_n), .btn_min(btn_min), .btn_hour(btn_hour), .btn_stop(btn_stop),
    .alarm_en(alarm_en), .cur_d0(cur_d0), .cur_d1(cur_d1), .cur_d2(cur_d2), .cur_d3(cur_d3),
    .cur_pm(cur_pm), .d0(a_d0), .d1(a_d1), .d2(a_d2), .d3(a_d3), .pm(a_pm), .ring(a_ring)
  );

  alarm_time_set #(.MODE24(1'b0), .REPEAT_DELAY(4), .REPEAT_PERIOD(2), .RING_CYCLES(64'd10)) dut12 (
    .clk(clk), .rst_n(rst_n), .btn_min(btn_min), .btn_hour(btn_hour), .btn_stop(btn_stop),
    .alarm_en(alarm_en), .cur_d0(cur_d0), .cur_d1(cur_d1), .cur_d2(cur_d2), .cur_d3(cur_d3),
    .cur_pm(cur_pm), .d0(b_d0), .d1(b_d1), .d2(b_d2), .d3(b_d3), .pm(b_pm), .ring(b_ring)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [17:0] pack(input bit p, input int h, input int m, input bit r);
    pack = {p, 4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), r};
  endfunction

  function automatic logic [17:0] obs24();
    obs24 = {a_pm, a_d3, a_d2, a_d1, a_d0, a_ring};
  endfunction

  function automatic logic [17:0] obs12();
    obs12 = {b_pm, b_d3, b_d2, b_d1, b_d0, b_ring};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cur(input int h, input int m, input bit p);
    cur_d0 = 4'(m % 10);
    cur_d1 = 4'(m / 10);
    cur_d2 = 4'(h % 10);
    cur_d3 = 4'(h / 10);
    cur_pm = p;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    btn_min = 1'b0; btn_hour = 1'b0; btn_stop = 1'b0; alarm_en = 1'b0;
    set_cur(0, 0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_min();
    btn_min = 1'b1; tick();
    btn_min = 1'b0; tick();
  endtask

  task automatic pulse_hour();
    btn_hour = 1'b1; tick();
    btn_hour = 1'b0; tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    btn_min = 1'b1; btn_hour = 1'b0; btn_stop = 1'b0; alarm_en = 1'b0;
    set_cur(0, 0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back(pack(0, 0, 0, 0));
    exp_q.push_back(pack(0, 12, 0, 0));
    got = obs24(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_fail++; $display("FAIL reset24 got=%h want=%h", got, want); end
    got = obs12(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_fail++; $display("FAIL reset12 got=%h want=%h", got, want); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) tick();
    exp_q.push_back(pack(0, 0, 0, 0));
    got = obs24(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_fail++; $display("FAIL held_through_reset got=%h want=%h", got, want); end
    btn_min = 1'b0;
    repeat (2) tick();
    exp_q.push_back(pack(0, 0, 0, 0));
    got = obs24(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_fail++; $display("FAIL release_after_reset got=%h want=%h", got, want); end
  endtask

  task automatic test_minutes();
    int m = 0;
    do_reset();
    for (int i = 1; i <= 60; i++) begin
      pulse_min();
      m = (m + 1) % 60;
      exp_q.push_back(pack(0, 0, m, 0));
      got = obs24(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_fail++; $display("FAIL minutes[%0d] got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_hour_hold();
    int h = 0;
    bit stepped = 1'b0;
    do_reset();
    btn_hour = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (stepped) h++;
      stepped = (c == 1) || (c >= 5 && ((c - 5) % 2 == 0));
      exp_q.push_back(pack(0, h, 0, 0));
      got = obs24(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_fail++; $display("FAIL hour_hold[%0d] got=%h want=%h", c, got, want); end
    end
    btn_hour = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      exp_q.push_back(pack(0, 5, 0, 0));
      got = obs24(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_fail++; $display("FAIL hour_release[%0d] got=%h want=%h", c, got, want); end
    end
  endtask

  task automatic test_mode12();
    int h = 12;
    bit p = 1'b0;
    do_reset();
    for (int i = 1; i <= 24; i++) begin
      pulse_hour();
      h = (h == 12) ? 1 : h + 1;
      if (h == 12) p = ~p;
      exp_q.push_back(pack(p, h, 0, 0));
      got = obs12(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_fail++; $display("FAIL mode12_hour[%0d] got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_ring();
    do_reset();
    for (int i = 0; i < 6; i++) pulse_hour();
    for (int i = 0; i < 30; i++) pulse_min();
    set_cur(6, 29, 1'b0);
    alarm_en = 1'b1;
    repeat (2) tick();
    exp_q.push_back(pack(0, 6, 30, 0));
    got = obs24(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_fail++; $display("FAIL ring_setup got=%h want=%h", got, want); end
    set_cur(6, 30, 1'b0);
    for (int t = 1; t <= 14; t++) begin
      tick();
      exp_q.push_back(pack(0, 6, 30, t <= 10));
      exp_q.push_back(pack(0, 6, 30, t <= 10));
      got = obs24(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_fail++; $display("FAIL ring24[%0d] got=%h want=%h", t, got, want); end
      got = obs12(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_fail++; $display("FAIL ring12[%0d] got=%h want=%h", t, got, want); end
    end
    // PM mismatch: only the 24 h instance should ring.
    set_cur(6, 29, 1'b1);
    repeat (2) tick();
    set_cur(6, 30, 1'b1);
    tick();
    exp_q.push_back(pack(0, 6, 30, 1));
    exp_q.push_back(pack(0, 6, 30, 0));
    got = obs24(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_fail++; $display("FAIL ring_pm24 got=%h want=%h", got, want); end
    got = obs12(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_fail++; $display("FAIL ring_pm12 got=%h want=%h", got, want); end
    repeat (11) tick();
  endtask

  task automatic test_stop();
    set_cur(6, 29, 1'b0); tick();
    set_cur(6, 30, 1'b0); tick();
    exp_q.push_back(pack(0, 6, 30, 1));
    got = obs24(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_fail++; $display("FAIL stop_pre got=%h want=%h", got, want); end
    btn_stop = 1'b1; tick();
    exp_q.push_back(pack(0, 6, 30, 0));
    got = obs24(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_fail++; $display("FAIL stop_btn got=%h want=%h", got, want); end
    btn_stop = 1'b0;
    repeat (3) tick();
    exp_q.push_back(pack(0, 6, 30, 0));
    got = obs24(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_fail++; $display("FAIL stop_no_rering got=%h want=%h", got, want); end
    set_cur(6, 29, 1'b0); tick();
    set_cur(6, 30, 1'b0); tick();
    btn_min = 1'b1;
    repeat (2) tick();
    exp_q.push_back(pack(0, 6, 31, 0));
    got = obs24(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_fail++; $display("FAIL stop_by_min got=%h want=%h", got, want); end
    btn_min = 1'b0; tick();
    // Stop edge coincident with a new match edge.
    set_cur(6, 31, 1'b0);
    btn_stop = 1'b1;
    tick();
    btn_stop = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      exp_q.push_back(pack(0, 6, 31, 0));
      got = obs24(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_fail++; $display("FAIL stop_precedence[%0d] got=%h want=%h", t, got, want); end
      tick();
    end
    set_cur(6, 30, 1'b0); tick();
    set_cur(6, 31, 1'b0); tick();
    alarm_en = 1'b0; tick();
    exp_q.push_back(pack(0, 6, 31, 0));
    got = obs24(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_fail++; $display("FAIL stop_by_disable got=%h want=%h", got, want); end
  endtask

  task automatic test_async_reset();
    alarm_en = 1'b1;
    set_cur(6, 30, 1'b0); tick();
    set_cur(6, 31, 1'b0); tick();
    exp_q.push_back(pack(0, 6, 31, 1));
    got = obs24(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_fail++; $display("FAIL async_pre_ring got=%h want=%h", got, want); end
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back(pack(0, 0, 0, 0));
    exp_q.push_back(pack(0, 12, 0, 0));
    got = obs24(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_fail++; $display("FAIL async_ring24 got=%h want=%h", got, want); end
    got = obs12(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_fail++; $display("FAIL async_ring12 got=%h want=%h", got, want); end
    alarm_en = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (2) tick();
    btn_hour = 1'b1;
    repeat (7) tick();
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back(pack(0, 0, 0, 0));
    exp_q.push_back(pack(0, 12, 0, 0));
    got = obs24(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_fail++; $display("FAIL async_repeat24 got=%h want=%h", got, want); end
    got = obs12(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_fail++; $display("FAIL async_repeat12 got=%h want=%h", got, want); end
    @(negedge clk) rst_n = 1'b1;
    repeat (6) tick();
    exp_q.push_back(pack(0, 0, 0, 0));
    got = obs24(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_fail++; $display("FAIL async_held_hour got=%h want=%h", got, want); end
    btn_hour = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_minutes();
    test_hour_hold();
    test_mode12();
    test_ring();
    test_stop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
